// File: rtl/sba_axi_master_if.sv
// AXI4 bus bundle shared by the SBA initiator and the interconnect slaves.
// Only the single-beat subset is exercised by the initiator.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 2,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [StrbWidth-1:0]      w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/sba_axi_master.sv
// System-bus-access initiator: one single-beat AXI transaction per debug request,
// with sizing, lane steering, alignment checks, bus-error reporting and a timeout.
module sba_axi_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 2,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned AXI_ID         = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_err_o,
    output logic        busy_o,
    AXI_BUS.Master      master
);
    typedef enum logic [2:0] {
        StIdle, StWrite, StWresp, StRead, StRdata, StResp, StDrain
    } state_e;

    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    state_e                    state_q;
    logic                      aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;
    logic                      aw_done_q, w_done_q, pend_b_q, pend_r_q;
    logic [31:0]               addr_q;
    logic [1:0]                size_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [3:0]                wstrb_q;
    logic                      rsp_valid_q;
    logic [31:0]               rdata_q;
    logic [1:0]                err_q;
    logic [CntW-1:0]           cnt_q;

    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        misaligned, timeout, pending_next, counting;
    logic [31:0] wdata_rep, r_shift, rdata_ext;
    logic [3:0]  strb;

    assign aw_hs = aw_valid_q & master.aw_ready;
    assign w_hs  = w_valid_q & master.w_ready;
    assign b_hs  = b_ready_q & master.b_valid;
    assign ar_hs = ar_valid_q & master.ar_ready;
    assign r_hs  = r_ready_q & master.r_valid;

    assign timeout  = (cnt_q == CntLast);
    assign counting = (state_q == StWrite) || (state_q == StWresp) ||
                      (state_q == StRead)  || (state_q == StRdata);

    // Anything on the bus still owed a handshake after this cycle.
    assign pending_next = (aw_valid_q & ~aw_hs) | (w_valid_q & ~w_hs) | (ar_valid_q & ~ar_hs) |
                          (pend_b_q & ~b_hs) | (pend_r_q & ~r_hs);

    always_comb begin
        misaligned = 1'b0;
        wdata_rep  = req_wdata_i;
        strb       = 4'hF;
        case (req_size_i)
            2'd0: begin
                wdata_rep = {4{req_wdata_i[7:0]}};
                strb      = 4'b0001 << req_addr_i[1:0];
            end
            2'd1: begin
                misaligned = req_addr_i[0];
                wdata_rep  = {2{req_wdata_i[15:0]}};
                strb       = 4'b0011 << req_addr_i[1:0];
            end
            2'd2:    misaligned = |req_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        r_shift   = master.r_data[31:0] >> {addr_q[1:0], 3'b000};
        rdata_ext = r_shift;
        case (size_q)
            2'd0:    rdata_ext = {24'd0, r_shift[7:0]};
            2'd1:    rdata_ext = {16'd0, r_shift[15:0]};
            default: rdata_ext = r_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            pend_b_q    <= 1'b0;
            pend_r_q    <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= '0;
            cnt_q       <= '0;
        end else begin
            // Channel bookkeeping runs in every state so late handshakes retire cleanly.
            if (aw_hs) begin
                aw_valid_q <= 1'b0;
                aw_done_q  <= 1'b1;
            end
            if (w_hs) begin
                w_valid_q <= 1'b0;
                w_done_q  <= 1'b1;
            end
            if (ar_hs) ar_valid_q <= 1'b0;
            if (b_hs) begin
                b_ready_q <= 1'b0;
                pend_b_q  <= 1'b0;
            end
            if (r_hs) begin
                r_ready_q <= 1'b0;
                pend_r_q  <= 1'b0;
            end
            if (counting) cnt_q <= cnt_q + 1'b1;

            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        // Count starts at 1 so the response lands TIMEOUT_CYCLES after acceptance.
                        cnt_q   <= CntW'(1);
                        addr_q  <= req_addr_i;
                        size_q  <= req_size_i;
                        rdata_q <= '0;
                        err_q   <= 2'd0;
                        if (misaligned) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            err_q       <= 2'd2;
                        end else if (req_we_i) begin
                            state_q    <= StWrite;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            aw_done_q  <= 1'b0;
                            w_done_q   <= 1'b0;
                            wdata_q    <= wdata_rep;
                            wstrb_q    <= strb;
                        end else begin
                            state_q    <= StRead;
                            ar_valid_q <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                        state_q   <= StWresp;
                        b_ready_q <= 1'b1;
                        pend_b_q  <= 1'b1;
                    end else if (timeout) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 2'd3;
                        b_ready_q   <= 1'b1;
                        pend_b_q    <= 1'b1;
                    end
                end
                StWresp: begin
                    if (b_hs) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        err_q       <= master.b_resp[1] ? 2'd1 : 2'd0;
                    end else if (timeout) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 2'd3;
                    end
                end
                StRead: begin
                    if (ar_hs) begin
                        state_q   <= StRdata;
                        r_ready_q <= 1'b1;
                        pend_r_q  <= 1'b1;
                    end else if (timeout) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 2'd3;
                        r_ready_q   <= 1'b1;
                        pend_r_q    <= 1'b1;
                    end
                end
                StRdata: begin
                    if (r_hs) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        err_q       <= master.r_resp[1] ? 2'd1 : 2'd0;
                        rdata_q     <= master.r_resp[1] ? 32'd0 : rdata_ext;
                    end else if (timeout) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 2'd3;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= pending_next ? StDrain : StIdle;
                    end
                end
                StDrain: begin
                    if (!pending_next) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.aw_addr   = AXI_ADDR_WIDTH'(addr_q);
    assign master.aw_len    = 8'd0;
    assign master.aw_size   = {1'b0, size_q};
    assign master.aw_burst  = 2'b01;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = 4'd0;
    assign master.aw_prot   = 3'd0;
    assign master.aw_qos    = 4'd0;
    assign master.aw_region = 4'd0;
    assign master.aw_user   = '0;
    assign master.aw_valid  = aw_valid_q;

    assign master.w_data  = wdata_q;
    assign master.w_strb  = wstrb_q;
    assign master.w_last  = 1'b1;
    assign master.w_user  = '0;
    assign master.w_valid = w_valid_q;

    assign master.b_ready = b_ready_q;

    assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.ar_addr   = AXI_ADDR_WIDTH'(addr_q);
    assign master.ar_len    = 8'd0;
    assign master.ar_size   = {1'b0, size_q};
    assign master.ar_burst  = 2'b01;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = 4'd0;
    assign master.ar_prot   = 3'd0;
    assign master.ar_qos    = 4'd0;
    assign master.ar_region = 4'd0;
    assign master.ar_user   = '0;
    assign master.ar_valid  = ar_valid_q;

    assign master.r_ready = r_ready_q;

    // IDs, user and low response bits are not needed with one transaction in flight.
    logic unused_bus;
    assign unused_bus = ^{master.b_id, master.b_user, master.b_resp[0], master.r_id,
                          master.r_user, master.r_last, master.r_resp[0]};
endmodule

// File: doc/sba_axi_master.md
# sba_axi_master

System-bus-access initiator for the debug path: accepts single read/write requests from the debug module and issues one single-beat AXI transaction per request on an `AXI_BUS` master port. It connects as an additional master on the AXI interconnect, next to the core's instruction-fetch and LSU masters. It is the initiator counterpart of the memory and peripheral AXI slaves. It handles byte/half/word sizing, lane steering, alignment checks, bus error reporting and a completion timeout.

## Interface
- `AXI_ADDR_WIDTH`, 32, AXI address width.
- `AXI_DATA_WIDTH`, 32, AXI data width; only 32 is supported.
- `AXI_ID_WIDTH`, 2, AXI ID width, matching the interconnect master-side ID width.
- `AXI_USER_WIDTH`, 1, AXI user width; user fields are driven to 0.
- `AXI_ID`, 0, constant ID placed on AWID and ARID.
- `TIMEOUT_CYCLES`, 1024, number of cycles after request acceptance before a timeout is reported; must be ≥ 4.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request ready; high only in IDLE.
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in 32: byte address.
- `req_size_i` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_wdata_i` in 32: write data, right-justified.
- `rsp_valid_o` out 1: response valid; held until accepted.
- `rsp_ready_i` in 1: response ready.
- `rsp_rdata_o` out 32: read data, right-justified and zero-extended; 0 for writes and errors.
- `rsp_err_o` out 2: 0 = OK, 1 = bus error, 2 = misaligned/illegal size, 3 = timeout.
- `busy_o` out 1: high in every state except IDLE.
- `master` AXI_BUS.Master: AXI port carrying the AW, W, B, AR and R channels.

## Operation
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, RESP, DRAIN.
- IDLE: a request is accepted when `req_valid_i` and `req_ready_o` are both high.
  - Misaligned request or size 3: go to RESP with err = 2; no bus traffic. Misaligned means half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Legal write: go to WRITE. Legal read: go to READ.
- AXI field values:
  - LEN = 0; SIZE = req_size; BURST = INCR.
  - ID = `AXI_ID`; PROT, LOCK, CACHE, QOS, REGION and USER = 0.
  - WLAST = 1; address = `req_addr_i` unmodified.
- Write data and strobe:
  - WDATA = req_wdata replicated across all lanes (byte ×4, half ×2).
  - WSTRB: byte = 1 << addr[1:0]; half = 2'b11 << addr[1:0]; word = 4'hF.
- WRITE: AWVALID and WVALID rise together.
  - Each valid drops independently after its own handshake, tracked with `aw_done` and `w_done` flags.
  - When both handshakes are done, go to WRESP.
- WRESP: BREADY = 1. On the B handshake, go to RESP with err = 1 if BRESP[1], else 0.
- READ: ARVALID = 1 until the AR handshake, then go to RDATA.
- RDATA: RREADY = 1. On the R handshake:
  - rdata = (RDATA >> 8·addr[1:0]), masked to the request size.
  - err = 1 if RRESP[1], else 0.
  - Go to RESP.
- RESP: `rsp_valid_o` = 1 with stable data and error code.
  - On `rsp_ready_i`: go to DRAIN if a bus handshake is still outstanding, else IDLE.
- Timeout counter:
  - Cleared on request acceptance; increments in WRITE, WRESP, READ and RDATA.
  - When the count reaches `TIMEOUT_CYCLES`: go to RESP with err = 3 and rdata = 0; mark outstanding channels.
  - Valids stay asserted until their handshakes complete (AXI rule: no valid withdrawal).
- DRAIN: keep all pending AXI valids asserted and hold BREADY/RREADY = 1 for the pending response; discard the returned data. When nothing is outstanding, go to IDLE.
- Only one transaction is outstanding at a time; BID/RID are not checked.

## Timing
- Reset values: every valid and ready output is 0, except `req_ready_o` = 1. `rsp_rdata_o` = 0, `rsp_err_o` = 0, `busy_o` = 0. State = IDLE.
- Asserting `rst_n` low mid-transaction returns the block to IDLE immediately; the in-flight transaction is abandoned.
- All AXI outputs are registered. Valids rise in the cycle after request acceptance (cycle 1 when acceptance is cycle 0).
- Best-case latency, with slaves ready and responding in the next cycle:
  - Write: AW/W handshake in cycle 1, B handshake in cycle 2, `rsp_valid_o` in cycle 3.
  - Read: AR handshake in cycle 1, R handshake in cycle 2, `rsp_valid_o` in cycle 3.
  - Error code 2: `rsp_valid_o` in cycle 1.
- The next request can be accepted in the cycle after the response handshake, provided DRAIN is not entered.
- A timeout and a completing handshake in the same cycle: the handshake wins and the real response is reported.
- `rsp_valid_o` and the response fields do not change while `rsp_ready_i` is low.

## Test plan
- Word write 0xDEADBEEF to 0x1000_0004; slave ready with BRESP OKAY.
  - AW addr 0x1000_0004, SIZE 2, WSTRB 4'hF.
  - `rsp_valid_o` in cycle 3 with err 0.
- Byte read at 0x1000_0003; slave returns 0xAABBCCDD.
  - ARSIZE 0; `rsp_rdata_o` = 0x0000_00AA, err 0.
- Half write 0x1234 to 0x1013_0002.
  - WDATA 0x1234_1234, WSTRB 4'b1100.
- Word read at 0x1000_0002, and a request with size 3.
  - err 2 for both, no AR/AW valid ever asserted, `rsp_valid_o` in cycle 1.
- Read at 0x3000_0000 answered with RRESP DECERR.
  - err 1, rdata 0.
- Slave stalls AWREADY for 1500 cycles with `TIMEOUT_CYCLES` = 1024.
  - err 3 reported 1024 cycles after acceptance; AWVALID stays high.
  - After AW/W/B complete, the block returns to IDLE and the next request succeeds.
- `rst_n` pulsed low while in WRESP.
  - All outputs return to their reset values immediately; IDLE; `req_ready_o` = 1.
